// File: rtl/imm_pkg.sv
// Shared types for the immediate-generation stage and the control decoder.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I    = 3'b000,
    IMM_S    = 3'b001,
    IMM_B    = 3'b010,
    IMM_J    = 3'b011,
    IMM_U    = 3'b100,
    IMM_Z    = 3'b101,
    IMM_SH   = 3'b110,
    IMM_RSVD = 3'b111
  } imm_src_e;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_ONE   = 2'b01,
    SKID_FULL  = 2'b10
  } skid_state_e;

endpackage

// File: rtl/imm_gen_stage_if.sv
// Valid/ready bus for imm_gen_stage: upstream entry in, extended immediate out.
interface imm_gen_stage_if
  import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);
    logic              in_valid_i;
    logic              in_ready_o;
    imm_src_e          imm_src_i;
    logic [24:0]       instr_i;
    logic [TAG_W-1:0]  tag_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [XLEN-1:0]   imm_ext_o;
    logic [TAG_W-1:0]  tag_o;
    logic              imm_err_o;

    modport slave (
        input  in_valid_i, imm_src_i, instr_i, tag_i, out_ready_i,
        output in_ready_o, out_valid_o, imm_ext_o, tag_o, imm_err_o
    );

    modport master (
        output in_valid_i, imm_src_i, instr_i, tag_i, out_ready_i,
        input  in_ready_o, out_valid_o, imm_ext_o, tag_o, imm_err_o
    );
endinterface

// File: rtl/imm_format.sv
// Combinational bit mapping from instruction bits [31:7] to an XLEN-wide immediate.
module imm_format
  import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  imm_src_e         imm_src_i,
    input  logic [24:0]      instr_i,
    output logic [XLEN-1:0]  imm_o,
    output logic             err_o
);
    // Indexed by original instruction bit numbers so the mapping reads like the ISA tables.
    logic [31:7] w_ins;
    assign w_ins = instr_i;

    always_comb begin
        // NOTE: defaults first so no path through the case leaves an output unassigned (no latch).
        imm_o = '0;
        err_o = 1'b0;
        case (imm_src_i)
            IMM_I:  imm_o = XLEN'($signed(w_ins[31:20]));
            IMM_S:  imm_o = XLEN'($signed({w_ins[31:25], w_ins[11:7]}));
            IMM_B:  imm_o = XLEN'($signed({w_ins[31], w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0}));
            IMM_J:  imm_o = XLEN'($signed({w_ins[31], w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0}));
            IMM_U:  imm_o = XLEN'($signed({w_ins[31:12], 12'b0}));
            IMM_Z:  imm_o = XLEN'(w_ins[19:15]);
            IMM_SH: imm_o = (XLEN == 64) ? XLEN'(w_ins[25:20]) : XLEN'(w_ins[24:20]);
            default: err_o = 1'b1;
        endcase
    end
endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage with valid/ready handshake and flush.
// Build option: define IMM_SKID_EN for a 2-entry skid buffer with registered in_ready_o.
module imm_gen_stage
  import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    imm_gen_stage_if.slave     bus
);
    logic [XLEN-1:0]  w_imm;
    logic             w_err;

    logic [XLEN-1:0]  r_imm;
    logic [TAG_W-1:0] r_tag;
    logic             r_err;
    logic             w_out_valid;
    logic             w_in_ready;

    imm_format #(.XLEN(XLEN)) u_format (
        .imm_src_i (bus.imm_src_i),
        .instr_i   (bus.instr_i),
        .imm_o     (w_imm),
        .err_o     (w_err)
    );

`ifdef IMM_SKID_EN
    skid_state_e      r_state;
    skid_state_e      w_state_nxt;
    logic             r_in_ready;
    logic [XLEN-1:0]  r_skid_imm;
    logic [TAG_W-1:0] r_skid_tag;
    logic             r_skid_err;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_load_out;
    logic             w_load_skid;
    logic             w_pop_skid;

    assign w_in_ready  = r_in_ready;
    assign w_out_valid = (r_state != SKID_EMPTY);
    assign w_in_fire   = bus.in_valid_i && r_in_ready;
    assign w_out_fire  = w_out_valid && bus.out_ready_i;

    always_comb begin
        w_state_nxt = r_state;
        w_load_out  = 1'b0;
        w_load_skid = 1'b0;
        w_pop_skid  = 1'b0;
        case (r_state)
            SKID_EMPTY: begin
                if (w_in_fire) begin
                    w_state_nxt = SKID_ONE;
                    w_load_out  = 1'b1;
                end
            end
            SKID_ONE: begin
                if (w_in_fire && w_out_fire) begin
                    w_load_out = 1'b1;
                end else if (w_in_fire) begin
                    w_state_nxt = SKID_FULL;
                    w_load_skid = 1'b1;
                end else if (w_out_fire) begin
                    w_state_nxt = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                // in_ready is low here, so only the drain of the output can happen.
                if (w_out_fire) begin
                    w_state_nxt = SKID_ONE;
                    w_pop_skid  = 1'b1;
                end
            end
            default: w_state_nxt = SKID_EMPTY;
        endcase
        if (flush_i) begin
            w_state_nxt = SKID_EMPTY;
            w_load_out  = 1'b0;
            w_load_skid = 1'b0;
            w_pop_skid  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: non-blocking for all sequential state so every register samples pre-edge values.
            r_state    <= SKID_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != SKID_FULL);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_imm <= '0;
            r_tag <= '0;
            r_err <= 1'b0;
        end else if (w_load_out) begin
            r_imm <= w_imm;
            r_tag <= bus.tag_i;
            r_err <= w_err;
        end else if (w_pop_skid) begin
            r_imm <= r_skid_imm;
            r_tag <= r_skid_tag;
            r_err <= r_skid_err;
        end
    end

    // NOTE: skid payload has no reset; it is only ever read after being written in ONE->FULL.
    always_ff @(posedge clk_i) begin
        if (w_load_skid) begin
            r_skid_imm <= w_imm;
            r_skid_tag <= bus.tag_i;
            r_skid_err <= w_err;
        end
    end
`else
    logic r_out_valid;
    logic w_load;

    assign w_out_valid = r_out_valid;
    assign w_in_ready  = !r_out_valid || bus.out_ready_i;
    assign w_load      = bus.in_valid_i && w_in_ready && !flush_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_out_valid <= 1'b0;
            r_imm       <= '0;
            r_tag       <= '0;
            r_err       <= 1'b0;
        end else begin
            if (flush_i) begin
                r_out_valid <= 1'b0;
            end else if (w_in_ready) begin
                r_out_valid <= bus.in_valid_i;
            end
            if (w_load) begin
                r_imm <= w_imm;
                r_tag <= bus.tag_i;
                r_err <= w_err;
            end
        end
    end
`endif

    assign bus.in_ready_o  = w_in_ready;
    assign bus.out_valid_o = w_out_valid;
    assign bus.imm_ext_o   = r_imm;
    assign bus.tag_o       = r_tag;
    assign bus.imm_err_o   = r_err;
endmodule
